w5300_bus_responder: RTL and testbench

Synthesizable slave-side model of the W5300 16-bit parallel host bus: it answers the `cs_n`/`rd_n`/`we_n`/`addr`/`data` accesses that the W5300 host driver issues, and it asserts `int_n` back to the driver. It holds a small register file and a socket-0 TX→RX loopback FIFO. It lets the driver and its config ROM sequence run on hardware or in simulation without a physical W5300. It sits in the test top in place of the chip pins, clocked by the 100 MHz PLL output.

---
 rtl/w5300_bus_responder_pkg.sv | 33 +++
 rtl/w5300_loopback_fifo.sv | 60 ++++++
 rtl/w5300_bus_responder.sv | 218 +++++++++++++++++++++
 tb/tb_w5300_bus_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/w5300_bus_responder_pkg.sv
// Shared definitions for the W5300 bus responder: register word indices,
// FIFO window addresses, IR bit positions and the bus FSM state type.
package w5300_bus_responder_pkg;

    // Register word indices (byte address = word * 2)
    localparam int unsigned MR_WORD  = 0;
    localparam int unsigned IR_WORD  = 1;
    localparam int unsigned IMR_WORD = 2;

    // IR bit positions
    localparam int unsigned IR_NONEMPTY_BIT = 0;
    localparam int unsigned IR_OVF_BIT      = 1;

    // Socket-0 loopback windows
    localparam logic [9:0] TX_FIFO_ADDR_DEF = 10'h22E;
    localparam logic [9:0] RX_FIFO_ADDR_DEF = 10'h230;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StWrite = 2'd2
    } bus_state_e;

    // Assemble the IR word from its two live bits; all other bits read 0.
    function automatic logic [15:0] ir_pack(input logic nonempty, input logic ovf);
        logic [15:0] v;
        v                  = '0;
        v[IR_NONEMPTY_BIT] = nonempty;
        v[IR_OVF_BIT]      = ovf;
        return v;
    endfunction

endpackage

// File: rtl/w5300_loopback_fifo.sv
// Synchronous first-word-fall-through FIFO for the socket-0 TX->RX loopback.
// Push while full and pop while empty are ignored; occupancy comes from a
// dedicated counter so full and empty never rely on pointer equality.
module w5300_loopback_fifo #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int unsigned Depth = 2 ** AW;
    localparam logic [AW:0] DepthCnt = (AW + 1)'(Depth);

    logic [DW-1:0] mem_q [Depth];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == DepthCnt);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign dout_o  = mem_q[rptr_q];
    assign count_o = count_q;

    // Pointer and occupancy bookkeeping; flush empties without touching storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/w5300_bus_responder.sv
// Slave-side model of the W5300 16-bit host bus. Strobes, address and data
// are double-synchronized, a three-state FSM sequences reads and writes, and
// a small register file plus a TX->RX loopback FIFO answer the driver.
module w5300_bus_responder
    import w5300_bus_responder_pkg::*;
#(
    parameter int unsigned REG_AW       = 6,
    parameter int unsigned FIFO_AW      = 4,
    parameter logic [9:0]  TX_FIFO_ADDR = TX_FIFO_ADDR_DEF,
    parameter logic [9:0]  RX_FIFO_ADDR = RX_FIFO_ADDR_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       addr,
    inout  wire  [15:0]      data,
    input  logic             cs_n,
    input  logic             rd_n,
    input  logic             we_n,
    input  logic             wrst_n,
    output logic             int_n,
    output logic [FIFO_AW:0] fifo_count,
    output logic             overflow
);
    localparam int unsigned      NumRegs  = 2 ** REG_AW;
    localparam logic [8:0]       RegWords = 9'(NumRegs);
    localparam logic [REG_AW-1:0] IrIdx   = REG_AW'(IR_WORD);

    // Synchronizer stages; control vector is {cs_n, rd_n, we_n, wrst_n}
    logic [3:0]  ctl_s1_q, ctl_s2_q;
    logic [9:1]  addr_s1_q, addr_s2_q;
    logic [15:0] data_s1_q, data_s2_q;
    logic        cs_s, rd_s, we_s, wrst_s;

    // Bus FSM and access registers
    bus_state_e  state_q, state_d;
    logic [15:0] rdata_q, wdata_q;
    logic [9:1]  waddr_q;
    logic        latch_rd, capture_wr, commit_wr;

    // Register file, status and FIFO interface
    logic [15:0]       regs_q [NumRegs];
    logic              ovf_q, ovf_d, ir_ne_q, int_n_q;
    logic [15:0]       rd_val, ir_live;
    logic              rd_is_reg, rd_is_rx, wr_is_reg, wr_is_tx;
    logic [REG_AW-1:0] rd_idx, wr_idx;
    logic              reg_we, ir_we, fifo_push, fifo_pop, ovf_set;
    logic [15:0]       fifo_dout;
    logic [FIFO_AW:0]  fifo_cnt;
    logic              fifo_full, fifo_empty;

    // 16-bit mode: the byte-select address bit carries no information.
    logic unused_addr0;
    assign unused_addr0 = addr[0];

    assign cs_s   = ctl_s2_q[3];
    assign rd_s   = ctl_s2_q[2];
    assign we_s   = ctl_s2_q[1];
    assign wrst_s = ctl_s2_q[0];

    // Two-flop synchronizers for every bus input; strobes idle high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctl_s1_q  <= '1;
            ctl_s2_q  <= '1;
            addr_s1_q <= '0;
            addr_s2_q <= '0;
            data_s1_q <= '0;
            data_s2_q <= '0;
        end else begin
            ctl_s1_q  <= {cs_n, rd_n, we_n, wrst_n};
            ctl_s2_q  <= ctl_s1_q;
            addr_s1_q <= addr[9:1];
            addr_s2_q <= addr_s1_q;
            data_s1_q <= data;
            data_s2_q <= data_s1_q;
        end
    end

    // Address decode for the live read address and the captured write address.
    always_comb begin
        rd_is_reg = (addr_s2_q < RegWords);
        rd_is_rx  = (addr_s2_q == RX_FIFO_ADDR[9:1]);
        rd_idx    = addr_s2_q[REG_AW:1];
        wr_is_reg = (waddr_q < RegWords);
        wr_is_tx  = (waddr_q == TX_FIFO_ADDR[9:1]);
        wr_idx    = waddr_q[REG_AW:1];
    end

    // Read data mux, sampled once on entry to READ.
    always_comb begin
        rd_val = '0;
        if (rd_is_reg) begin
            rd_val = (rd_idx == IrIdx) ? ir_pack(ir_ne_q, ovf_q) : regs_q[rd_idx];
        end else if (rd_is_rx && !fifo_empty) begin
            rd_val = fifo_dout;
        end
    end

    // FSM next-state: read wins over write; chip reset forces IDLE and blocks all actions.
    always_comb begin
        state_d    = state_q;
        latch_rd   = 1'b0;
        capture_wr = 1'b0;
        commit_wr  = 1'b0;
        fifo_pop   = 1'b0;
        if (!wrst_s) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!cs_s && !rd_s) begin
                        state_d  = StRead;
                        latch_rd = 1'b1;
                        fifo_pop = rd_is_rx && !fifo_empty;
                    end else if (!cs_s && !we_s) begin
                        state_d    = StWrite;
                        capture_wr = 1'b1;
                    end
                end
                StRead: begin
                    if (cs_s || rd_s) state_d = StIdle;
                end
                StWrite: begin
                    if (cs_s || we_s) begin
                        state_d   = StIdle;
                        commit_wr = 1'b1;
                    end else begin
                        capture_wr = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Write commit decode and IR overflow next-state.
    always_comb begin
        reg_we    = commit_wr && wr_is_reg && (wr_idx != IrIdx);
        ir_we     = commit_wr && wr_is_reg && (wr_idx == IrIdx);
        fifo_push = commit_wr && wr_is_tx && !fifo_full;
        ovf_set   = commit_wr && wr_is_tx && fifo_full;
        ovf_d     = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ir_we && wdata_q[IR_OVF_BIT]) begin
            ovf_d = 1'b0;
        end
        ir_live = ir_pack(!fifo_empty, ovf_q);
    end

    // FSM state, read latch and write capture; the commit uses the value
    // captured while the synchronized strobe was still low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            rdata_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch_rd) rdata_q <= rd_val;
            if (capture_wr) begin
                waddr_q <= addr_s2_q;
                wdata_q <= data_s2_q;
            end
        end
    end

    // Plain register file (IR slot is never written here).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
        end else if (!wrst_s) begin
            for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
        end else if (reg_we) begin
            regs_q[wr_idx] <= wdata_q;
        end
    end

    // Status: sticky overflow, registered FIFO-non-empty and registered interrupt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q   <= 1'b0;
            ir_ne_q <= 1'b0;
            int_n_q <= 1'b1;
        end else if (!wrst_s) begin
            ovf_q   <= 1'b0;
            ir_ne_q <= 1'b0;
            int_n_q <= 1'b1;
        end else begin
            ovf_q   <= ovf_d;
            ir_ne_q <= !fifo_empty;
            int_n_q <= ~|(ir_live & regs_q[IMR_WORD]);
        end
    end

    w5300_loopback_fifo #(
        .AW (FIFO_AW),
        .DW (16)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (!wrst_s),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (wdata_q),
        .dout_o  (fifo_dout),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign data       = (state_q == StRead) ? rdata_q : 16'hzzzz;
    assign int_n      = int_n_q;
    assign fifo_count = fifo_cnt;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_w5300_bus_responder.sv
// Self-checking bench for w5300_bus_responder. Read expectations are queued
// when a read is launched and compared when the responder drives the bus.
// The bus carries a pull-up, so an undriven bus reads 16'hFFFF.
module tb_w5300_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  addr;
    logic        cs_n, rd_n, we_n, wrst_n;
    logic [15:0] drv_val;
    logic        drv_en;
    tri1  [15:0] data;
    wire         int_n;
    wire  [4:0]  fifo_count;
    wire         overflow;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q [$];

    localparam logic [15:0] BusIdle = 16'hFFFF;

    assign data = drv_en ? drv_val : 16'hzzzz;

    always #5 clk = ~clk;

    w5300_bus_responder dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .data       (data),
        .cs_n       (cs_n),
        .rd_n       (rd_n),
        .we_n       (we_n),
        .wrst_n     (wrst_n),
        .int_n      (int_n),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Write: strobes low 4 cycles, then returns 3 cycles after we_n rises (commit edge).
    task automatic bus_write(input logic [9:0] a, input logic [15:0] v);
        addr    = a;
        drv_val = v;
        drv_en  = 1'b1;
        cs_n    = 1'b0;
        we_n    = 1'b0;
        cycles(4);
        we_n = 1'b1;
        cs_n = 1'b1;
        cycles(3);
        drv_en = 1'b0;
    endtask

    // Read: data must be valid 4 cycles after rd_n falls and released 3 after it rises.
    task automatic bus_read(input logic [9:0] a, input logic [15:0] exp, input string tag);
        addr = a;
        cs_n = 1'b0;
        rd_n = 1'b0;
        exp_q.push_back(exp);
        cycles(4);
        check_eq(tag, data, exp_q.pop_front());
        cycles(2);
        rd_n = 1'b1;
        cs_n = 1'b1;
        cycles(3);
        check_eq({tag, "_release"}, data, BusIdle);
        cycles(1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        addr    = '0;
        cs_n    = 1'b1;
        rd_n    = 1'b1;
        we_n    = 1'b1;
        wrst_n  = 1'b1;
        drv_val = '0;
        drv_en  = 1'b0;
        cycles(4);
        rst = 1'b0;
        cycles(3);

        // Reset state
        check_eq("rst_int_n", {15'b0, int_n}, 16'h0001);
        check_eq("rst_count", {11'b0, fifo_count}, 16'h0000);
        check_eq("rst_overflow", {15'b0, overflow}, 16'h0000);
        check_eq("rst_data", data, BusIdle);

        // Register write/read
        bus_write(10'h004, 16'h00A5);
        bus_read(10'h004, 16'h00A5, "imr_rd");
        bus_write(10'h000, 16'hBEEF);
        bus_read(10'h000, 16'hBEEF, "mr_rd");
        bus_write(10'h07E, 16'h5A5A);
        bus_read(10'h07F, 16'h5A5A, "top_reg_rd");
        bus_read(10'h100, 16'h0000, "unmapped_rd");
        bus_read(10'h002, 16'h0000, "ir_empty_rd");

        // FIFO loopback
        bus_write(10'h22E, 16'h1234);
        check_eq("push1_count", {11'b0, fifo_count}, 16'd1);
        bus_write(10'h22E, 16'h5678);
        check_eq("push2_count", {11'b0, fifo_count}, 16'd2);
        cycles(2);
        check_eq("ne_int_n", {15'b0, int_n}, 16'h0000);
        bus_read(10'h002, 16'h0001, "ir_ne_rd");
        bus_read(10'h230, 16'h1234, "pop1_rd");
        check_eq("pop1_count", {11'b0, fifo_count}, 16'd1);
        bus_read(10'h230, 16'h5678, "pop2_rd");
        check_eq("pop2_count", {11'b0, fifo_count}, 16'd0);
        bus_read(10'h002, 16'h0000, "ir_cleared_rd");
        check_eq("empty_int_n", {15'b0, int_n}, 16'h0001);

        // Empty pop
        bus_read(10'h230, 16'h0000, "empty_pop_rd");
        check_eq("empty_pop_count", {11'b0, fifo_count}, 16'd0);

        // Overflow and interrupt
        bus_write(10'h004, 16'h0002);
        for (int i = 1; i <= 17; i++) begin
            bus_write(10'h22E, 16'h1000 + 16'(i));
            if (i == 16) begin
                check_eq("full_count", {11'b0, fifo_count}, 16'd16);
                check_eq("full_no_ovf", {15'b0, overflow}, 16'h0000);
            end
        end
        cycles(2);
        check_eq("ovf_count", {11'b0, fifo_count}, 16'd16);
        check_eq("ovf_flag", {15'b0, overflow}, 16'h0001);
        check_eq("ovf_int_n", {15'b0, int_n}, 16'h0000);
        bus_read(10'h002, 16'h0003, "ir_ovf_rd");
        bus_write(10'h002, 16'h0002);
        cycles(2);
        check_eq("w1c_flag", {15'b0, overflow}, 16'h0000);
        check_eq("w1c_int_n", {15'b0, int_n}, 16'h0001);
        bus_read(10'h230, 16'h1001, "first_word_rd");
        check_eq("after_pop_count", {11'b0, fifo_count}, 16'd15);
        bus_write(10'h004, 16'h0001);
        cycles(2);
        check_eq("imr0_int_n", {15'b0, int_n}, 16'h0000);

        // Chip reset during a held read
        addr = 10'h004;
        cs_n = 1'b0;
        rd_n = 1'b0;
        exp_q.push_back(16'h0001);
        cycles(4);
        check_eq("held_rd", data, exp_q.pop_front());
        wrst_n = 1'b0;
        cycles(3);
        check_eq("wrst_data_hiz", data, BusIdle);
        cycles(2);
        rd_n = 1'b1;
        cs_n = 1'b1;
        cycles(1);
        wrst_n = 1'b1;
        cycles(4);
        check_eq("wrst_count", {11'b0, fifo_count}, 16'd0);
        check_eq("wrst_overflow", {15'b0, overflow}, 16'h0000);
        check_eq("wrst_int_n", {15'b0, int_n}, 16'h0001);
        bus_read(10'h000, 16'h0000, "wrst_mr_rd");
        bus_read(10'h002, 16'h0000, "wrst_ir_rd");
        bus_read(10'h004, 16'h0000, "wrst_imr_rd");
        bus_read(10'h07E, 16'h0000, "wrst_top_rd");

        // System reset during a write
        bus_write(10'h004, 16'h0001);
        bus_write(10'h22E, 16'h4242);
        cycles(2);
        check_eq("pre_rst_int_n", {15'b0, int_n}, 16'h0000);
        addr    = 10'h004;
        drv_val = 16'h0003;
        drv_en  = 1'b1;
        cs_n    = 1'b0;
        we_n    = 1'b0;
        cycles(4);
        rst = 1'b1;
        cycles(1);
        check_eq("rst_mid_int_n", {15'b0, int_n}, 16'h0001);
        we_n = 1'b1;
        cs_n = 1'b1;
        cycles(2);
        drv_en = 1'b0;
        rst    = 1'b0;
        cycles(5);
        check_eq("rst_wr_count", {11'b0, fifo_count}, 16'd0);
        check_eq("rst_wr_int_n", {15'b0, int_n}, 16'h0001);
        bus_read(10'h004, 16'h0000, "rst_wr_imr_rd");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
